// File: rtl/uart_pkg.sv
// uart_pkg -- shared definitions for the memory-mapped UART transmitter.
//   * Serializer state encodings (plain 2-bit constants so the encoding stays
//     stable for legacy tools and waveform viewers).
//   * Register offsets relative to BASE_ADDR.
//   * Bit positions of the fields in the STATUS register.
package uart_pkg;

    typedef logic [1:0] state_t;

    localparam state_t ST_IDLE  = 2'd0;
    localparam state_t ST_START = 2'd1;
    localparam state_t ST_DATA  = 2'd2;
    localparam state_t ST_STOP  = 2'd3;

    localparam logic [31:0] TXDATA_OFS = 32'd0;
    localparam logic [31:0] STATUS_OFS = 32'd4;

    // STATUS = {28'b0, ovf, busy, empty, full}
    localparam int STAT_FULL  = 0;
    localparam int STAT_EMPTY = 1;
    localparam int STAT_BUSY  = 2;
    localparam int STAT_OVF   = 3;

endpackage

// File: rtl/uart_tx_mmio_if.sv
// uart_tx_mmio_if -- CPU data-memory port seen by the UART peripheral.
//   WE : store enable            (master -> slave)
//   A  : byte address            (master -> slave)
//   WD : store data              (master -> slave)
//   RD : combinational load data (slave -> master)
interface uart_tx_mmio_if;

    logic        WE;
    logic [31:0] A;
    logic [31:0] WD;
    logic [31:0] RD;

    modport master (output WE, output A, output WD, input RD);
    modport slave  (input WE, input A, input WD, output RD);

endinterface

// File: rtl/fifo_sync.sv
// fifo_sync -- single-clock FIFO with combinational head output.
//   clk, rst_n : clock and asynchronous active-low reset (pointers only)
//   push, din  : write din on the rising edge when not full
//   pop, dout  : dout always shows the head entry; pop advances it when not empty
//   full/empty : derived from read/write pointers carrying one extra wrap bit
// DEPTH must be a power of two and at least 2.
module fifo_sync #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout,
    output logic             full,
    output logic             empty
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0]      wr_ptr_q, wr_ptr_d;
    logic [AW:0]      rd_ptr_q, rd_ptr_d;
    logic             do_push, do_pop;

    // Equal indices: same wrap bit means empty, opposite wrap bit means full.
    assign empty   = (wr_ptr_q == rd_ptr_q);
    assign full    = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                     (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign dout    = mem[rd_ptr_q[AW-1:0]];

    // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
        if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
    end

    // NOTE: sequential state uses non-blocking assignments so all flops update from pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    // NOTE: storage is deliberately not reset; empty pointers make stale contents unreachable.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr_q[AW-1:0]] <= din;
    end

endmodule

// File: rtl/uart_tx_mmio.sv
// uart_tx_mmio -- memory-mapped 8N1 UART transmitter with a transmit FIFO.
//   clk  : single clock, rising edge
//   rst  : asynchronous active-low reset; aborts any frame, empties the FIFO
//   bus  : CPU data-memory port (WE, A, WD in; combinational RD out)
//   tx   : registered serial line, idle high
// Registers (decoded on A[31:2]):
//   BASE_ADDR+0 TXDATA  write: queue WD[7:0]; reads as 0
//   BASE_ADDR+4 STATUS  read {28'b0, ovf, busy, empty, full}; write WD[3]=1 clears ovf
module uart_tx_mmio
    import uart_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR    = 32'h0000_1000,
    parameter int          CLKS_PER_BIT = 868,
    parameter int          FIFO_DEPTH   = 8
) (
    input  logic          clk,
    input  logic          rst,
    uart_tx_mmio_if.slave bus,
    output logic          tx
);

    localparam logic [31:0]      TXDATA_ADDR = BASE_ADDR + TXDATA_OFS;
    localparam logic [31:0]      STATUS_ADDR = BASE_ADDR + STATUS_OFS;
    localparam int               CNT_W       = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CNT_W-1:0] BAUD_LAST   = CNT_W'(CLKS_PER_BIT - 1);

    logic             sel_txdata, sel_status;
    logic             wr_txdata, wr_status;
    logic             fifo_full, fifo_empty, fifo_pop;
    logic [7:0]       fifo_dout;
    logic             busy;
    logic [31:0]      rd;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] baud_q, baud_d;
    logic [2:0]       bit_idx_q, bit_idx_d;
    logic [7:0]       shreg_q, shreg_d;
    logic             tx_q, tx_d;
    logic             ovf_q, ovf_d;

    // Byte-lane bits of the address and the upper store-data bits carry no meaning here.
    logic unused_bus_bits;
    assign unused_bus_bits = &{1'b0, bus.A[1:0], bus.WD[31:8]};

    assign sel_txdata = (bus.A[31:2] == TXDATA_ADDR[31:2]);
    assign sel_status = (bus.A[31:2] == STATUS_ADDR[31:2]);
    assign wr_txdata  = bus.WE && sel_txdata;
    assign wr_status  = bus.WE && sel_status;

    // A write while full is discarded inside the FIFO; ovf records the loss.
    fifo_sync #(
        .WIDTH (8),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst_n (rst),
        .push  (wr_txdata),
        .pop   (fifo_pop),
        .din   (bus.WD[7:0]),
        .dout  (fifo_dout),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    // tx is computed one edge ahead so the registered line changes exactly on
    // the edge that enters each bit period.
    always_comb begin
        state_d   = state_q;
        baud_d    = baud_q;
        bit_idx_d = bit_idx_q;
        shreg_d   = shreg_q;
        tx_d      = tx_q;
        fifo_pop  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                tx_d = 1'b1;
                if (!fifo_empty) begin
                    fifo_pop = 1'b1;
                    shreg_d  = fifo_dout;
                    baud_d   = '0;
                    state_d  = ST_START;
                    tx_d     = 1'b0;
                end
            end
            ST_START: begin
                if (baud_q == BAUD_LAST) begin
                    baud_d    = '0;
                    bit_idx_d = '0;
                    state_d   = ST_DATA;
                    tx_d      = shreg_q[0];
                end else begin
                    baud_d = baud_q + 1'b1;
                end
            end
            ST_DATA: begin
                if (baud_q == BAUD_LAST) begin
                    baud_d = '0;
                    if (bit_idx_q == 3'd7) begin
                        state_d = ST_STOP;
                        tx_d    = 1'b1;
                    end else begin
                        bit_idx_d = bit_idx_q + 1'b1;
                        shreg_d   = {1'b0, shreg_q[7:1]};
                        tx_d      = shreg_q[1];
                    end
                end else begin
                    baud_d = baud_q + 1'b1;
                end
            end
            ST_STOP: begin
                if (baud_q == BAUD_LAST) begin
                    baud_d  = '0;
                    state_d = ST_IDLE;
                    tx_d    = 1'b1;
                end else begin
                    baud_d = baud_q + 1'b1;
                end
            end
            default: begin
                state_d = ST_IDLE;
                tx_d    = 1'b1;
            end
        endcase
    end

    // full is the pre-edge value, so a write on the same edge as a pop is still dropped.
    always_comb begin
        ovf_d = ovf_q;
        if (wr_txdata && fifo_full) begin
            ovf_d = 1'b1;
        end else if (wr_status && bus.WD[STAT_OVF]) begin
            ovf_d = 1'b0;
        end
    end

    assign busy = (state_q != ST_IDLE);

    always_comb begin
        rd = '0;
        if (sel_status) begin
            rd[STAT_FULL]  = fifo_full;
            rd[STAT_EMPTY] = fifo_empty;
            rd[STAT_BUSY]  = busy;
            rd[STAT_OVF]   = ovf_q;
        end
    end

    assign bus.RD = rd;
    assign tx     = tx_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= ST_IDLE;
            baud_q    <= '0;
            bit_idx_q <= '0;
            shreg_q   <= '0;
            tx_q      <= 1'b1;
            ovf_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            baud_q    <= baud_d;
            bit_idx_q <= bit_idx_d;
            shreg_q   <= shreg_d;
            tx_q      <= tx_d;
            ovf_q     <= ovf_d;
        end
    end

endmodule

// File: tb/tb_uart_tx_mmio.sv
// tb_uart_tx_mmio -- self-checking bench for uart_tx_mmio (CLKS_PER_BIT=4, FIFO_DEPTH=4).
// The reference model describes the line as whole 8N1 frames: each accepted
// byte produces start/data/stop bits of CPB cycles, frames follow each other
// with one idle cycle in between, and a burst into an idle, empty block keeps
// only the first FIFO_DEPTH+1 bytes.
module tb_uart_tx_mmio;

    localparam int          CPB   = 4;
    localparam int          DEPTH = 4;
    localparam logic [31:0] BASE  = 32'h0000_1000;

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic tx;

    always #5 clk = ~clk;

    uart_tx_mmio_if bus ();

    uart_tx_mmio #(
        .BASE_ADDR    (BASE),
        .CLKS_PER_BIT (CPB),
        .FIFO_DEPTH   (DEPTH)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus),
        .tx  (tx)
    );

    int         n_pass  = 0;
    int         n_total = 0;
    int         cyc     = 0;
    logic [7:0] exp_q[$];
    logic [7:0] wr_q[$];
    int         starts[$];
    logic       exp_ovf;

    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #500000;
        $display("FAIL watchdog: observed no end of test, required finish before timeout");
        $fatal(1, "timeout");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h required %0h", tag, obs, exp);
    endtask

    function automatic logic frame_bit(input logic [7:0] b, input int i);
        if (i == 0) return 1'b0;
        if (i == 9) return 1'b1;
        return b[i-1];
    endfunction

    function automatic logic [31:0] stat(input logic ovf, input logic busy,
                                         input logic empty, input logic full);
        return {28'b0, ovf, busy, empty, full};
    endfunction

    task automatic write_bus(input logic [31:0] addr, input logic [31:0] data);
        bus.WE = 1'b1;
        bus.A  = addr;
        bus.WD = data;
        @(posedge clk);
        #1;
        bus.WE = 1'b0;
    endtask

    task automatic read_check(input logic [31:0] addr, input logic [31:0] exp, input string tag);
        bus.A = addr;
        #1;
        check(tag, bus.RD, exp);
    endtask

    // Writes wr_q to TXDATA on consecutive edges; upper data bits are random junk.
    task automatic burst();
        for (int i = 0; i < wr_q.size(); i++) begin
            bus.WE = 1'b1;
            bus.A  = BASE + {$urandom_range(0, 3)};
            bus.WD = $urandom;
            bus.WD[7:0] = wr_q[i];
            @(posedge clk);
            #1;
        end
        bus.WE = 1'b0;
        bus.A  = BASE;
    endtask

    // The first byte leaves the FIFO one edge after it lands, DEPTH more fit
    // behind it, and a 40-cycle frame outlasts any short burst.
    task automatic model_burst();
        exp_q = {};
        exp_ovf = 1'b0;
        for (int i = 0; i < wr_q.size(); i++) begin
            if (i < DEPTH + 1) exp_q.push_back(wr_q[i]);
            else exp_ovf = 1'b1;
        end
    endtask

    // Entered just after the edge preceding the first pop edge.
    task automatic expect_stream(input bit chk_status);
        logic [7:0] b;
        while (exp_q.size() > 0) begin
            b = exp_q.pop_front();
            for (int i = 0; i < 10 * CPB; i++) begin
                @(posedge clk);
                #1;
                if (i == 0) starts.push_back(cyc);
                check($sformatf("frame %02h sample %0d", b, i), 32'(tx), 32'(frame_bit(b, i / CPB)));
                if (chk_status) check("busy in frame", 32'(bus.RD[2]), 32'd1);
            end
            @(posedge clk);
            #1;
            check("idle gap tx", 32'(tx), 32'd1);
            if (chk_status) check("busy in idle gap", 32'(bus.RD[2]), 32'd0);
        end
    endtask

    task automatic run_burst();
        fork
            burst();
            begin
                @(posedge clk);
                #1;
                expect_stream(1'b0);
            end
        join
    endtask

    initial begin
        bus.WE = 1'b0;
        bus.A  = BASE + 32'd4;
        bus.WD = '0;
        exp_ovf = 1'b0;

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        check("reset tx", 32'(tx), 32'd1);
        check("reset status", bus.RD, stat(0, 0, 1, 0));
        rst = 1'b1;

        // Single byte, upper store bits ignored
        write_bus(BASE, 32'hFFFF_FF55);
        read_check(BASE + 32'd4, stat(0, 0, 0, 0), "status after push");
        check("tx before pop", 32'(tx), 32'd1);
        exp_q = {8'h55};
        expect_stream(1'b1);
        read_check(BASE + 32'd4, stat(0, 0, 1, 0), "status after single");

        // Overflow: six writes in consecutive cycles
        wr_q = {8'h41, 8'h42, 8'h43, 8'h44, 8'h45, 8'h46};
        model_burst();
        run_burst();
        read_check(BASE + 32'd4, stat(exp_ovf, 0, 1, 0), "ovf after burst");
        write_bus(BASE + 32'd4, 32'h7);
        read_check(BASE + 32'd4, stat(1, 0, 1, 0), "ovf kept by write without bit3");
        write_bus(BASE + 32'd4, 32'h8);
        read_check(BASE + 32'd4, stat(0, 0, 1, 0), "ovf cleared");

        // Write while full on the same edge as a pop is still dropped
        wr_q = {8'h61, 8'h62, 8'h63, 8'h64, 8'h65};
        model_burst();
        fork
            begin
                burst();
                repeat (37) @(posedge clk);
                #1;
                write_bus(BASE, 32'h99);
            end
            begin
                @(posedge clk);
                #1;
                expect_stream(1'b0);
            end
        join
        read_check(BASE + 32'd4, stat(1, 0, 1, 0), "ovf on full+pop edge");
        write_bus(BASE + 32'd4, 32'h8);
        read_check(BASE + 32'd4, stat(0, 0, 1, 0), "ovf cleared again");

        // Back-to-back frames
        wr_q = {8'hA5, 8'h3C};
        model_burst();
        starts = {};
        run_burst();
        check("b2b frame count", 32'(starts.size()), 32'd2);
        if (starts.size() == 2) check("b2b start spacing", 32'(starts[1] - starts[0]), 32'd41);

        // Address decode
        read_check(BASE + 32'd7, stat(0, 0, 1, 0), "read 0x1007");
        read_check(BASE, 32'd0, "read TXDATA");
        read_check(BASE + 32'd8, 32'd0, "read 0x1008");
        write_bus(BASE + 32'd8, 32'hFF);
        bus.A = BASE + 32'd4;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk);
            #1;
            check("tx after stray write", 32'(tx), 32'd1);
        end
        read_check(BASE + 32'd4, stat(0, 0, 1, 0), "status after stray write");
        write_bus(BASE + 32'd3, 32'hC3);
        bus.A = BASE + 32'd4;
        exp_q = {8'hC3};
        expect_stream(1'b1);

        // Randomized bursts
        for (int r = 0; r < 4; r++) begin
            wr_q = {};
            for (int i = 0; i < int'($urandom_range(1, 7)); i++) wr_q.push_back(8'($urandom));
            model_burst();
            run_burst();
            read_check(BASE + 32'd4, stat(exp_ovf, 0, 1, 0), "random burst status");
            write_bus(BASE + 32'd4, 32'h8);
            read_check(BASE + 32'd4, stat(0, 0, 1, 0), "random burst ovf clear");
        end

        // Reset in the middle of DATA bit 3, with a second byte queued
        wr_q = {8'hF7, 8'h12};
        burst();
        repeat (17) @(posedge clk);
        #1;
        check("tx in DATA bit3", 32'(tx), 32'd0);
        rst = 1'b0;
        #1;
        check("tx forced by reset", 32'(tx), 32'd1);
        read_check(BASE + 32'd4, stat(0, 0, 1, 0), "status in reset");
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b1;
        read_check(BASE + 32'd4, stat(0, 0, 1, 0), "status after release");
        write_bus(BASE, 32'h5A);
        bus.A = BASE + 32'd4;
        exp_q = {8'h5A};
        expect_stream(1'b1);
        for (int i = 0; i < 50; i++) begin
            @(posedge clk);
            #1;
            check("no residual frame", 32'(tx), 32'd1);
        end
        read_check(BASE + 32'd4, stat(0, 0, 1, 0), "final status");

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/uart_tx_mmio.md
UART_TX_MMIO -- requirements
Module: uart_tx_mmio

Interface
REQ-001 The block SHALL have parameter BASE_ADDR, default 32'h0000_1000, the memory-mapped base address of the peripheral.
REQ-002 The block SHALL have parameter CLKS_PER_BIT, default 868, the number of clk cycles per serial bit (100 MHz / 115200).
REQ-003 The block SHALL have parameter FIFO_DEPTH, default 8, the number of transmit bytes buffered; it SHALL be a power of two.
REQ-004 The block SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-005 The block SHALL have port rst, input, 1 bit: asynchronous, active-low reset.
REQ-006 The block SHALL have port WE, input, 1 bit: CPU data-memory write enable.
REQ-007 The block SHALL have port A, input, 32 bits: CPU data-memory address.
REQ-008 The block SHALL have port WD, input, 32 bits: CPU store data.
REQ-009 The block SHALL have port RD, output, 32 bits: combinational read data for the CPU load path.
REQ-010 The block SHALL have port tx, output, 1 bit: registered serial line, idle high.

Function
REQ-011 Address decode SHALL compare A[31:2] only; A[1:0] SHALL be ignored.
- TXDATA = BASE_ADDR+0
- STATUS = BASE_ADDR+4
REQ-012 A write with WE=1 to TXDATA while the FIFO is not full SHALL push WD[7:0] on that edge; WD[31:8] SHALL be ignored.
REQ-013 A write to TXDATA while full SHALL be dropped and SHALL set sticky bit ovf, even if a pop happens on the same edge (full is sampled before the edge).
REQ-014 A write to STATUS with WD[3]=1 SHALL clear ovf; all other STATUS bits SHALL be read-only.
REQ-015 RD SHALL equal {28'b0, ovf, busy, empty, full} when A decodes to STATUS; RD SHALL be 0 for any other address, including TXDATA.
REQ-016 busy SHALL be 1 whenever the FSM is not in IDLE.
REQ-017 The serializer FSM SHALL have states IDLE, START, DATA and STOP, with a baud counter and a 3-bit bit index.
REQ-018 In IDLE with the FIFO non-empty, the FSM SHALL pop the head byte into a shift register on the next edge and enter START.
REQ-019 tx SHALL be 0 in START, shift-register bits LSB-first in DATA, and 1 in STOP and IDLE.
REQ-020 Each of START, each of the 8 DATA bits, and STOP SHALL last exactly CLKS_PER_BIT cycles.
REQ-021 After STOP the FSM SHALL return to IDLE for exactly one cycle before the next pop, giving a back-to-back frame period of 10*CLKS_PER_BIT+1 cycles.
REQ-022 Latency: for a byte written at edge k into an empty FIFO with the FSM in IDLE, the pop SHALL occur at edge k+1 and tx SHALL fall immediately after edge k+1.
REQ-023 A simultaneous push (not full) and pop SHALL keep the FIFO count unchanged and lose no data.
REQ-024 FIFO read and write pointers SHALL wrap modulo FIFO_DEPTH; full and empty SHALL be derived from an extra pointer MSB.

Reset
REQ-025 While rst=0 the block SHALL hold: state=IDLE, tx=1, FIFO empty (full=0, empty=1), ovf=0, counters=0.
REQ-026 Reset asserted mid-frame SHALL abort the frame immediately, force tx=1 asynchronously, and discard all FIFO contents.
REQ-027 After rst deasserts, the first push SHALL be accepted on the next rising edge.

Structure
REQ-028 Package uart_pkg SHALL hold the FSM state enum and the constants TXDATA_OFS=0, STATUS_OFS=4 and the STATUS bit positions.
REQ-029 The FIFO SHALL be a separate sub-module, fifo_sync (parameters WIDTH, DEPTH; ports push, pop, din, dout, full, empty).
REQ-030 The serializer, address decode and ovf logic SHALL reside in uart_tx_mmio.

Verification (bench uses CLKS_PER_BIT=4, FIFO_DEPTH=4)
REQ-031 Single byte: write 32'hFFFF_FF55 to 0x1000 -> tx falls one cycle later; line shows 0,1,0,1,0,1,0,1,0,1 at 4 cycles each; busy=1 throughout; status returns to 0x2.
REQ-032 Overflow: 6 writes of 0x41..0x46 in consecutive cycles -> 0x41..0x45 transmitted (1 popped plus 4 queued), 0x46 dropped; STATUS bit3=1; write 0x8 to 0x1004 -> bit3=0.
REQ-033 Back-to-back: queue 0xA5, 0x3C -> second start bit begins exactly 41 cycles after the first.
REQ-034 Decode: read 0x1007 returns STATUS; write to 0x1008 has no effect; read 0x1000 returns 0.
REQ-035 Reset mid-frame: assert rst during DATA bit 3 -> tx=1 within the same cycle; after release, STATUS=0x2 and no residual bytes are sent.
